// File: rtl/rv_prefetch_pkg.sv
// Shared constants and types for the rv32i instruction-fetch front end.
package rv_prefetch_pkg;
    localparam int unsigned RV_ILEN     = 32;
    localparam logic [31:0] RV_INSN_NOP = 32'h0000_0013;
    localparam logic [31:0] RV_PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fq_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with flush; the head entry is read straight from storage.
module rv_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned LW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [LW-1:0]    level_o,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;

    // Flush dominates; caller guarantees no push when full or pop when empty.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + PW'(1);
            if (pop_i)  rptr_d = rptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];
endmodule

// File: rtl/rv_prefetch.sv
// Prefetch front end: streams sequential words into a small queue, flushes on redirect.
module rv_prefetch
    import rv_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RST_VECTOR = 32'h0000_0000,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      mem_i_addr,
    output logic             mem_i_rstrb,
    input  logic [31:0]      mem_i_rdata,
    input  logic             mem_i_rbusy,
    input  logic             redir_valid,
    input  logic [31:0]      redir_addr,
    output logic             insn_valid,
    output logic [31:0]      insn_data,
    output logic [31:0]      insn_addr,
    input  logic             insn_ready,
    output logic [LW-1:0]    level,
    output logic [CNT_W-1:0] stat_fetches
);
    logic [31:0]      fpc_q, fpc_d;
    logic [CNT_W-1:0] stat_q, stat_d;
    logic             beat, pop;
    fq_entry_t        head, wentry;

    // No bypass: a full queue never requests, even if it is popped this cycle.
    assign mem_i_rstrb = rst_n && !redir_valid && (level < LW'(DEPTH));
    assign beat        = mem_i_rstrb && !mem_i_rbusy;
    assign pop         = insn_valid && insn_ready;
    assign mem_i_addr  = fpc_q;

    always_comb begin
        fpc_d  = fpc_q;
        stat_d = stat_q;
        if (redir_valid) begin
            fpc_d = align_pc(redir_addr);
        end else if (beat) begin
            fpc_d  = fpc_q + RV_PC_STEP;
            stat_d = stat_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q  <= RST_VECTOR;
            stat_q <= '0;
        end else begin
            fpc_q  <= fpc_d;
            stat_q <= stat_d;
        end
    end

    assign wentry.addr = fpc_q;
    assign wentry.data = mem_i_rdata;

    rv_sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redir_valid),
        .push_i  (beat),
        .wdata_i (wentry),
        .pop_i   (pop),
        .level_o (level),
        .rdata_o (head)
    );

    assign insn_valid   = (level != '0);
    assign insn_addr    = head.addr;
    assign insn_data    = head.data;
    assign stat_fetches = stat_q;
endmodule

// File: tb/tb_rv_prefetch.sv
// Directed bench for rv_prefetch: vector table plus hand-written corner sequences.
module tb_rv_prefetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_i_addr, mem_i_rdata;
    logic        mem_i_rstrb;
    logic        mem_i_rbusy = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_addr = '0;
    logic        insn_valid, insn_ready = 1'b0;
    logic [31:0] insn_data, insn_addr;
    logic [2:0]  level;
    logic [31:0] stat_fetches;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: data is a fixed function of the address.
    assign mem_i_rdata = mem_i_addr ^ 32'hA5A5_0000;

    rv_prefetch #(.DEPTH(4), .RST_VECTOR(32'h0), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_i_addr(mem_i_addr), .mem_i_rstrb(mem_i_rstrb),
        .mem_i_rdata(mem_i_rdata), .mem_i_rbusy(mem_i_rbusy),
        .redir_valid(redir_valid), .redir_addr(redir_addr),
        .insn_valid(insn_valid), .insn_data(insn_data), .insn_addr(insn_addr),
        .insn_ready(insn_ready), .level(level), .stat_fetches(stat_fetches)
    );

    typedef struct {
        logic        busy, ready, redir;
        logic [31:0] raddr;
        logic        e_rstrb;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_iaddr;
        logic [2:0]  e_level;
        logic [31:0] e_stat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_i_rbusy = 0; insn_ready = 0; redir_valid = 0; redir_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_rstrb", 32'(mem_i_rstrb), 32'd0);
        chk("rst_valid", 32'(insn_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_addr", mem_i_addr, 32'h0);
        chk("rst_stat", stat_fetches, 32'd0);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic b, r, d, input logic [31:0] ra,
                                input logic rs, input logic [31:0] a, input logic v,
                                input logic [31:0] ia, input logic [2:0] l,
                                input logic [31:0] s);
        vec_t x;
        x.busy = b; x.ready = r; x.redir = d; x.raddr = ra;
        x.e_rstrb = rs; x.e_addr = a; x.e_valid = v; x.e_iaddr = ia;
        x.e_level = l; x.e_stat = s;
        return x;
    endfunction

    initial begin
        logic [31:0] exp_next;
        int          pops;

        //        busy rdy redir raddr         rstrb addr          valid iaddr         lvl stat
        vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0,          0, 32'h0,          0, 0));
        vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4,          1, 32'h0,          1, 1));
        vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'h8,          1, 32'h0,          2, 2));
        vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'hC,          1, 32'h0,          3, 3));
        vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h10,         1, 32'h0,          4, 4));
        vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h10,         1, 32'h0,          4, 4));
        vt.push_back(mk(0, 1, 0, 32'h0,        0, 32'h10,         1, 32'h0,          4, 4));
        vt.push_back(mk(0, 1, 0, 32'h0,        1, 32'h10,         1, 32'h4,          3, 4));
        vt.push_back(mk(0, 1, 0, 32'h0,        1, 32'h14,         1, 32'h8,          3, 5));
        vt.push_back(mk(0, 1, 0, 32'h0,        1, 32'h18,         1, 32'hC,          3, 6));
        // redirect to 0x1003 while level 3 and busy: request abandoned
        vt.push_back(mk(1, 0, 1, 32'h1003,     0, 32'h1C,         1, 32'h10,         3, 7));
        vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'h1000,       0, 32'h0,          0, 7));
        vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'h1004,       1, 32'h1000,       1, 8));
        // pop + redirect in the same cycle with level 2; target near the top of memory
        vt.push_back(mk(0, 1, 1, 32'hFFFF_FFF8, 0, 32'h1008,      1, 32'h1000,       2, 9));
        vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFF8,  0, 32'h0,          0, 9));
        vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFF8,  1, 10));
        vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0,          1, 32'hFFFF_FFF8,  2, 11));
        vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4,          1, 32'hFFFF_FFF8,  3, 12));
        vt.push_back(mk(0, 1, 0, 32'h0,        0, 32'h8,          1, 32'hFFFF_FFF8,  4, 13));
        vt.push_back(mk(0, 1, 0, 32'h0,        1, 32'h8,          1, 32'hFFFF_FFFC,  3, 13));
        vt.push_back(mk(0, 1, 0, 32'h0,        1, 32'hC,          1, 32'h0,          3, 14));

        do_reset();
        foreach (vt[i]) begin
            mem_i_rbusy = vt[i].busy; insn_ready = vt[i].ready;
            redir_valid = vt[i].redir; redir_addr = vt[i].raddr;
            #1;
            chk($sformatf("v%0d_rstrb", i), 32'(mem_i_rstrb), 32'(vt[i].e_rstrb));
            chk($sformatf("v%0d_addr", i), mem_i_addr, vt[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(insn_valid), 32'(vt[i].e_valid));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(vt[i].e_level));
            chk($sformatf("v%0d_stat", i), stat_fetches, vt[i].e_stat);
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d_iaddr", i), insn_addr, vt[i].e_iaddr);
                chk($sformatf("v%0d_idata", i), insn_data, vt[i].e_iaddr ^ 32'hA5A5_0000);
            end
            @(negedge clk);
        end
        mem_i_rbusy = 0; insn_ready = 0; redir_valid = 0;

        // rbusy held 3 cycles on address 0x8
        do_reset();
        repeat (2) @(negedge clk);
        mem_i_rbusy = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("busy_addr", mem_i_addr, 32'h8);
            chk("busy_level", 32'(level), 32'd2);
            @(negedge clk);
        end
        mem_i_rbusy = 0;
        #1;
        chk("busy_addr_drop", mem_i_addr, 32'h8);
        chk("busy_rstrb_drop", 32'(mem_i_rstrb), 32'd1);
        @(negedge clk);
        mem_i_rbusy = 1;
        #1;
        chk("busy_level_after", 32'(level), 32'd3);
        chk("busy_stat_after", stat_fetches, 32'd3);
        insn_ready = 1;
        for (int k = 0; k < 3; k++) begin
            chk("busy_order", insn_addr, 32'(k * 4));
            @(negedge clk); #1;
        end
        chk("busy_empty", 32'(insn_valid), 32'd0);
        mem_i_rbusy = 0; insn_ready = 0;

        // continuous pop, 100 cycles: no loss, no duplication
        do_reset();
        insn_ready = 1;
        exp_next = 32'h0;
        pops = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (c >= 1) chk("stream_level", 32'(level), 32'd1);
            if (insn_valid) begin
                chk("stream_addr", insn_addr, exp_next);
                chk("stream_data", insn_data, exp_next ^ 32'hA5A5_0000);
                exp_next += 4;
                pops++;
            end
            @(negedge clk);
        end
        chk("stream_pops", 32'(pops), 32'd99);
        insn_ready = 0;

        // async reset mid-burst, not clock aligned
        do_reset();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rstrb", 32'(mem_i_rstrb), 32'd0);
        chk("arst_valid", 32'(insn_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_stat", stat_fetches, 32'd0);
        chk("arst_addr", mem_i_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_first_rstrb", 32'(mem_i_rstrb), 32'd1);
        chk("arst_first_addr", mem_i_addr, 32'h0);
        @(negedge clk); #1;
        chk("arst_first_head", insn_addr, 32'h0);
        chk("arst_first_level", 32'(level), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
